sprite_pixel_fetch: RTL and testbench
=====================================

# sprite_pixel_fetch

Address-generation and alignment stage that sits directly upstream of the sprite image BRAM, a single-port read-first RAM in HIGH_PERFORMANCE mode with 2-cycle read latency. It maps the incoming raster position (hcount/vcount) onto a sprite-local address and drives the RAM port. It delays all video timing signals by the RAM latency so `pixel_out` lines up with its coordinates. During blanking it grants a host write port (Manta memory or loader) access to the same RAM port.

## Interface
Parameters:
- `SPRITE_W`, 64, sprite width in pixels; power of two
- `SPRITE_H`, 64, sprite height in pixels
- `PIXEL_W`, 12, RAM word width (RGB444)
- `HCOUNT_W`, 11, raster x counter width
- `VCOUNT_W`, 10, raster y counter width
- `TRANSPARENT`, 12'h000, colour treated as see-through

Derived: `ADDR_W = $clog2(SPRITE_W*SPRITE_H)`.

Ports:
- `clk`  in  1  single clock; also drives the RAM `clka`
- `rst_n`  in  1  asynchronous, active-low reset
- `hcount_in`  in  HCOUNT_W  raster x
- `vcount_in`  in  VCOUNT_W  raster y
- `hsync_in`, `vsync_in`, `blank_in`  in  1 each  raster timing (vsync active-high)
- `x_in`  in  HCOUNT_W  requested sprite left edge
- `y_in`  in  VCOUNT_W  requested sprite top edge
- `wr_valid`  in  1  host write request
- `wr_ready`  out  1  host write accepted this cycle
- `wr_addr`  in  ADDR_W  host write address
- `wr_data`  in  PIXEL_W  host write data
- `ram_addr`  out  ADDR_W  to RAM `addra`
- `ram_din`  out  PIXEL_W  to RAM `dina`
- `ram_we`  out  1  to RAM `wea`
- `ram_en`  out  1  to RAM `ena`
- `ram_regce`  out  1  to RAM `regcea`
- `ram_dout`  in  PIXEL_W  from RAM `douta`
- `pixel_out`  out  PIXEL_W  sprite colour, aligned
- `pixel_valid`  out  1  sprite pixel present and opaque
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `blank_out`  out  as inputs  timing delayed 2 cycles

## Operation
- Position latch:
  - `x_q`/`y_q` capture `x_in`/`y_in` on the cycle after a `vsync_in` rising edge. Edge detection uses a registered copy of `vsync_in`.
  - The position never changes mid-frame.
- Hit test (stage 0, combinational on the inputs):
  - `hit = (hcount_in >= x_q) && (hcount_in < x_q+SPRITE_W) && (vcount_in >= y_q) && (vcount_in < y_q+SPRITE_H) && !blank_in`.
  - Sums are computed one bit wider than the operand, so a sprite near the right or bottom edge does not wrap.
- Read address: `((vcount_in - y_q) << log2(SPRITE_W)) | (hcount_in - x_q)`, truncated to ADDR_W. Used only when `hit`; otherwise the address is don't-care.
- Host write port:
  - `wr_ready = blank_in`.
  - When `wr_valid && wr_ready`: `ram_addr = wr_addr`, `ram_din = wr_data`, `ram_we = 1`, and the hit bit entering the pipeline is forced to 0.
  - `ram_we` is never asserted outside blanking.
- RAM control: `ram_en = 1` and `ram_regce = 1` whenever `rst_n` is high.
- Pipeline:
  - A 2-stage shift register carries hit, hcount, vcount, hsync, vsync and blank.
  - Output stage: `pixel_out = ram_dout` when the delayed hit is set, else 0; `pixel_valid` = delayed hit (gated as in Configuration).
- Reset:
  - All pipeline registers, `x_q`/`y_q`, the vsync edge register and all outputs go to 0 immediately.
  - Reset asserted mid-line discards in-flight pixels; the first valid output is 2 cycles after deassertion.
  - The position latch stays at (0,0) until the next vsync rising edge.

## Timing
- Latency from `hcount_in` to `pixel_out`/`hcount_out` is exactly 2 cycles, matching the RAM's HIGH_PERFORMANCE output register. The alignment breaks if the RAM is built LOW_LATENCY.
- `wr_ready` is combinational from `blank_in`. A write completes in the RAM on the accepting edge, with no backpressure beyond blanking.
- A vsync rising edge and a new `x_in` in the same cycle latch the new value one cycle later.
- `hcount_in == x_q + SPRITE_W - 1` is the last hit column; `== x_q + SPRITE_W` is a miss.

## Configuration
- `SPRITE_FETCH_TRANSPARENCY_EN`:
  - Defined: `pixel_valid = hit_d2 && (ram_dout != TRANSPARENT)`, and `pixel_out` is 0 when transparent.
  - Undefined: `pixel_valid = hit_d2` and the `TRANSPARENT` compare logic is absent. The parameter is accepted but unused.

## Structure
- Shared package `sprite_pkg`:
  - `SPRITE_RAM_LATENCY = 2`
  - `typedef struct packed` `vid_timing_t` holding {hcount, vcount, hsync, vsync, blank}
  - `pixel_t` (PIXEL_W wide)
- One sub-module `vid_timing_delay`: parameterised N-stage delay of `vid_timing_t` plus the hit bit, with async active-low reset. Instantiated with N = `SPRITE_RAM_LATENCY`.

## Test plan
Bench uses the real read-first RAM with SPRITE_W = SPRITE_H = 64 and a ramp init where `mem[a] = a[11:0]`.
- Sprite latched at (100,50); raster at (110,60) -> `ram_addr` = 10*64+10 = 650; 2 cycles later `pixel_out` = 12'h28A, `pixel_valid` = 1, `hcount_out` = 110.
- Raster at (164,60) with x = 100 -> `pixel_valid` = 0 and `pixel_out` = 0. Same test with x = 2000 (11-bit, near max) -> no wrap, `pixel_valid` = 0 across the whole line.
- `x_in` changed to 300 mid-frame -> output position unchanged until the vsync rising edge; sprite appears at 300 in the next frame.
- Host write of 12'hABC to address 0 while `blank_in` = 1 -> `wr_ready` = 1 and `ram_we` pulses; a later frame reads 12'hABC at the sprite origin. Same request with `blank_in` = 0 -> `wr_ready` = 0 and `ram_we` = 0.
- With `SPRITE_FETCH_TRANSPARENCY_EN`, address 0 holding 12'h000 -> origin pixel has `pixel_valid` = 0. Without the macro -> `pixel_valid` = 1.
- `rst_n` pulsed low mid-line -> all outputs are 0 in the same cycle; after release, `pixel_valid` stays 0 until the next frame's vsync latches a position.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite fetch path.
// Latency: none (declarations only). Backpressure: n/a.
package sprite_pkg;

    localparam int SPRITE_RAM_LATENCY = 2;
    localparam int SPR_PIXEL_W        = 12;
    localparam int VID_HCOUNT_W       = 11;
    localparam int VID_VCOUNT_W       = 10;

    typedef logic [SPR_PIXEL_W-1:0] pixel_t;

    typedef struct packed {
        logic [VID_HCOUNT_W-1:0] hcount;
        logic [VID_VCOUNT_W-1:0] vcount;
        logic                    hsync;
        logic                    vsync;
        logic                    blank;
    } vid_timing_t;

endpackage

// File: rtl/vid_timing_delay.sv
// vid_timing_delay: N-stage shift register for raster timing plus the sprite hit bit.
// Latency: exactly N cycles. Backpressure: none, advances every clock.
module vid_timing_delay
    import sprite_pkg::*;
#(
    parameter int N = SPRITE_RAM_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  vid_timing_t vid_in,
    input  logic        hit_in,
    output vid_timing_t vid_out,
    output logic        hit_out
);

    vid_timing_t vid_q [N];
    vid_timing_t vid_d [N];
    logic [N-1:0] hit_q;
    logic [N-1:0] hit_d;

    always_comb begin
        vid_d[0] = vid_in;
        hit_d    = '0;
        hit_d[0] = hit_in;
        for (int i = 1; i < N; i++) begin
            vid_d[i] = vid_q[i-1];
            hit_d[i] = hit_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                vid_q[i] <= '0;
            end
            hit_q <= '0;
        end else begin
            vid_q <= vid_d;
            hit_q <= hit_d;
        end
    end

    assign vid_out = vid_q[N-1];
    assign hit_out = hit_q[N-1];

endmodule

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: raster -> sprite BRAM address, host write port shared during blanking.
// Latency: 2 cycles hcount_in -> pixel_out/timing outputs. Backpressure: writes only while blank_in.
// Optional: SPRITE_FETCH_TRANSPARENCY_EN masks pixels equal to TRANSPARENT.
module sprite_pixel_fetch
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 64,
    parameter int PIXEL_W  = 12,
    parameter int HCOUNT_W = 11,
    parameter int VCOUNT_W = 10,
    parameter logic [PIXEL_W-1:0] TRANSPARENT = 12'h000,
    localparam int ADDR_W = $clog2(SPRITE_W*SPRITE_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                blank_in,
    input  logic [HCOUNT_W-1:0] x_in,
    input  logic [VCOUNT_W-1:0] y_in,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PIXEL_W-1:0]  wr_data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [PIXEL_W-1:0]  ram_din,
    output logic                ram_we,
    output logic                ram_en,
    output logic                ram_regce,
    input  logic [PIXEL_W-1:0]  ram_dout,
    output logic [PIXEL_W-1:0]  pixel_out,
    output logic                pixel_valid,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                blank_out
);

    localparam int LOG2W = $clog2(SPRITE_W);

    logic                vs_q, vs_d;
    logic                pos_vld_q, pos_vld_d;
    logic [HCOUNT_W-1:0] x_q, x_d;
    logic [VCOUNT_W-1:0] y_q, y_d;
    logic                vs_rise;

    // Position is only trusted once a vsync edge has latched it after reset.
    always_comb begin
        vs_rise   = vsync_in & ~vs_q;
        vs_d      = vsync_in;
        x_d       = x_q;
        y_d       = y_q;
        pos_vld_d = pos_vld_q;
        if (vs_rise) begin
            x_d       = x_in;
            y_d       = y_in;
            pos_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q      <= 1'b0;
            pos_vld_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            vs_q      <= vs_d;
            pos_vld_q <= pos_vld_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    logic [HCOUNT_W:0]   x_end;
    logic [VCOUNT_W:0]   y_end;
    logic                hit;
    logic                wr_fire;
    logic [ADDR_W-1:0]   rd_addr;
    vid_timing_t         vid_s0;
    vid_timing_t         vid_d2;
    logic                hit_d2;
    logic                opaque;

    // One extra bit on the far edges keeps a sprite near the raster limit from wrapping.
    always_comb begin
        x_end   = {1'b0, x_q} + (HCOUNT_W+1)'(SPRITE_W);
        y_end   = {1'b0, y_q} + (VCOUNT_W+1)'(SPRITE_H);
        wr_fire = rst_n && blank_in && wr_valid;
        hit     = pos_vld_q && !blank_in && !wr_fire
                  && (hcount_in >= x_q) && ({1'b0, hcount_in} < x_end)
                  && (vcount_in >= y_q) && ({1'b0, vcount_in} < y_end);
        rd_addr = (ADDR_W'(vcount_in - y_q) << LOG2W) | ADDR_W'(hcount_in - x_q);

        wr_ready  = blank_in && rst_n;
        ram_en    = rst_n;
        ram_regce = rst_n;
        ram_we    = wr_fire;
        ram_din   = wr_fire ? wr_data : '0;
        ram_addr  = !rst_n ? '0 : (wr_fire ? wr_addr : rd_addr);

        vid_s0.hcount = hcount_in;
        vid_s0.vcount = vcount_in;
        vid_s0.hsync  = hsync_in;
        vid_s0.vsync  = vsync_in;
        vid_s0.blank  = blank_in;
    end

    vid_timing_delay #(
        .N (SPRITE_RAM_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .vid_in  (vid_s0),
        .hit_in  (hit),
        .vid_out (vid_d2),
        .hit_out (hit_d2)
    );

`ifdef SPRITE_FETCH_TRANSPARENCY_EN
    assign opaque = (ram_dout != TRANSPARENT);
`else
    logic unused_transparent;
    assign unused_transparent = ^TRANSPARENT;
    assign opaque = 1'b1;
`endif

    always_comb begin
        pixel_valid = hit_d2 && opaque;
        pixel_out   = pixel_valid ? ram_dout : '0;
        hcount_out  = vid_d2.hcount;
        vcount_out  = vid_d2.vcount;
        hsync_out   = vid_d2.hsync;
        vsync_out   = vid_d2.vsync;
        blank_out   = vid_d2.blank;
    end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Bench for sprite_pixel_fetch with a 2-cycle read-first RAM model and a queue-based reference.
module tb_sprite_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, x_in = '0, hcount_out;
    logic [9:0]  vcount_in = '0, y_in = '0, vcount_out;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b1, wr_valid = 1'b0;
    logic [11:0] wr_addr = '0, wr_data = '0;
    logic        wr_ready, ram_we, ram_en, ram_regce, pixel_valid, hsync_out, vsync_out, blank_out;
    logic [11:0] ram_addr, ram_din, ram_dout, pixel_out;

    sprite_pixel_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .x_in(x_in), .y_in(y_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_en(ram_en), .ram_regce(ram_regce), .ram_dout(ram_dout),
        .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out)
    );

    always #5 clk = ~clk;

    // Read-first single-port RAM with output register (2-cycle read).
    logic [11:0] mem [4096];
    logic [11:0] ram_s1 = '0;
    initial ram_dout = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_s1 <= mem[ram_addr];
        end
        if (ram_regce) ram_dout <= ram_s1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: sprite origin, whether one is latched, shadow image, expected outputs.
    int          mx, my;
    bit          pv, prev_vs;
    logic [11:0] gold [4096];
    logic [36:0] q [$];
    bit          seen_val  [2048];
    logic [11:0] seen_pix  [2048];
    logic [11:0] seen_addr [2048];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        q.push_back('0);
        q.push_back('0);
        mx = 0; my = 0; pv = 0; prev_vs = 0;
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 2048; i++) begin
            seen_val[i] = 0; seen_pix[i] = '0; seen_addr[i] = '0;
        end
    endtask

    task automatic drive_phase();
        int h, v, addr;
        bit hit, we, pval;
        logic [11:0] px;
        #1;
        h  = int'(hcount_in);
        v  = int'(vcount_in);
        we = wr_valid && blank_in;
        hit = pv && !blank_in && h >= mx && h < mx + 64 && v >= my && v < my + 64;
        addr = (v - my) * 64 + (h - mx);
        chk("wr_ready", wr_ready, blank_in);
        chk("ram_we", ram_we, we);
        chk("ram_en_regce", {ram_en, ram_regce}, 2'b11);
        if (we) chk("wr_port", {ram_addr, ram_din}, {wr_addr, wr_data});
        if (hit) chk("rd_addr", ram_addr, addr[11:0]);
        seen_addr[h] = ram_addr;
        px = '0;
        if (hit) px = gold[addr];
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
        pval = hit && (px != 12'h000);
`else
        pval = hit;
`endif
        q.push_back({pval, pval ? px : 12'h000, hcount_in, vcount_in, hsync_in, vsync_in, blank_in});
        if (we) gold[wr_addr] = wr_data;
        if (vsync_in && !prev_vs) begin
            mx = int'(x_in); my = int'(y_in); pv = 1;
        end
        prev_vs = vsync_in;
    endtask

    task automatic clock_phase();
        logic [36:0] e;
        @(posedge clk);
        #1;
        e = q.pop_front();
        e = q[0];
        chk("pipe_out", {pixel_valid, pixel_out, hcount_out, vcount_out, hsync_out, vsync_out, blank_out}, e);
        if (!blank_out) begin
            seen_val[hcount_out] = pixel_valid;
            seen_pix[hcount_out] = pixel_out;
        end
    endtask

    task automatic cyc();
        drive_phase();
        clock_phase();
    endtask

    task automatic vsync_frame(input int x, input int y);
        blank_in = 1'b1; wr_valid = 1'b0;
        x_in = 11'(x); y_in = 10'(y);
        vsync_in = 1'b1; cyc(); cyc();
        vsync_in = 1'b0; cyc(); cyc();
    endtask

    task automatic line(input int v, input int h0, input int h1);
        blank_in = 1'b0; vsync_in = 1'b0; wr_valid = 1'b0;
        vcount_in = 10'(v);
        clear_seen();
        for (int h = h0; h <= h1; h++) begin
            hcount_in = 11'(h);
            cyc();
        end
        blank_in = 1'b1;
        repeat (3) cyc();
    endtask

    function automatic int count_valid();
        int n = 0;
        for (int i = 0; i < 2048; i++) n += int'(seen_val[i]);
        return n;
    endfunction

    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem[a]  = 12'(a);
            gold[a] = 12'(a);
        end
        clear_seen();

        #2;
        chk("reset_outputs", {pixel_valid, pixel_out, hcount_out, vcount_out, hsync_out, vsync_out,
                              blank_out, ram_we, ram_en, ram_regce, wr_ready, ram_addr}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Basic hit at (100,50), raster row 60.
        vsync_frame(100, 50);
        line(60, 96, 170);
        chk("addr650", seen_addr[110], 12'd650);
        chk("pix_28A", {seen_val[110], seen_pix[110]}, {1'b1, 12'h28A});
        chk("last_col", {seen_val[163], seen_pix[163]}, {1'b1, 12'h2BF});
        chk("miss_164", {seen_val[164], seen_pix[164]}, 13'h0);

        // Sprite near the right limit must not wrap into low columns.
        vsync_frame(2000, 50);
        line(60, 0, 1279);
        chk("no_wrap", count_valid(), 0);
        line(60, 1990, 2047);
        chk("edge_hit", {seen_val[1999], seen_val[2000], seen_pix[2000]}, {1'b0, 1'b1, 12'h280});

        // Mid-frame x change only takes effect after the next vsync edge.
        vsync_frame(100, 50);
        x_in = 11'd300;
        line(60, 96, 170);
        chk("midframe_hold", {seen_val[100], seen_pix[100]}, {1'b1, 12'h280});
        vsync_frame(300, 50);
        line(60, 290, 370);
        chk("moved", {seen_val[299], seen_val[300], seen_pix[300]}, {1'b0, 1'b1, 12'h280});

        // Host write accepted in blanking, refused in active video.
        blank_in = 1'b1; wr_valid = 1'b1; wr_addr = 12'h000; wr_data = 12'hABC;
        drive_phase();
        chk("wr_accept", {wr_ready, ram_we}, 2'b11);
        clock_phase();
        blank_in = 1'b0; hcount_in = '0; vcount_in = '0; wr_data = 12'h555;
        drive_phase();
        chk("wr_blocked", {wr_ready, ram_we}, 2'b00);
        clock_phase();
        wr_valid = 1'b0; blank_in = 1'b1;
        vsync_frame(300, 50);
        line(50, 295, 310);
        chk("wr_readback", {seen_val[300], seen_pix[300]}, {1'b1, 12'hABC});

        // Origin pixel equal to the transparent colour.
        wr_valid = 1'b1; wr_addr = 12'h000; wr_data = 12'h000;
        cyc();
        wr_valid = 1'b0;
        vsync_frame(300, 50);
        line(50, 295, 310);
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
        chk("transparent", {seen_val[300], seen_pix[300]}, 13'h0000);
`else
        chk("transparent", {seen_val[300], seen_pix[300]}, 13'h1000);
`endif

        // Reset in the middle of a line with hits in flight.
        vsync_frame(300, 50);
        clear_seen();
        blank_in = 1'b0; vcount_in = 10'd60;
        for (int h = 290; h <= 320; h++) begin
            hcount_in = 11'(h);
            cyc();
        end
        chk("pre_reset_hit", seen_val[305], 1);
        rst_n = 1'b0;
        #1;
        chk("reset_midline", {pixel_valid, pixel_out, hcount_out, vcount_out, hsync_out, vsync_out,
                              blank_out, ram_we, ram_en, ram_regce, wr_ready, ram_addr}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clear_seen();
        for (int h = 321; h <= 400; h++) begin
            hcount_in = 11'(h);
            cyc();
        end
        chk("post_reset_quiet", count_valid(), 0);
        blank_in = 1'b1;
        repeat (3) cyc();
        vsync_frame(300, 50);
        line(60, 290, 370);
        chk("post_reset_frame", seen_val[320], 1);

        // Randomised traffic around the current sprite position.
        for (int i = 0; i < 3000; i++) begin
            vsync_in = ($urandom_range(0, 40) == 0);
            hsync_in = 1'($urandom_range(0, 1));
            blank_in = ($urandom_range(0, 5) == 0);
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 12'($urandom);
            wr_data  = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                x_in = 11'($urandom);
                y_in = 10'($urandom);
            end
            hcount_in = 11'(mx + int'($urandom_range(0, 90)) - 10);
            vcount_in = 10'(my + int'($urandom_range(0, 90)) - 10);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
